// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - echo delay-line sequencer for a shared single-port sample RAM (optional ECHO_DELAY_RAMP_EN)
module echo_delay_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] delay_target,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] echo_data,
    output logic              echo_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] delay_cur
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};
    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT);

    state_t            state;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] rd_r;
    logic [ADDR_W-1:0] delay_next;
    logic [DATA_W-1:0] echo_sel;

    // Delay to apply to the sample being accepted this cycle
    always_comb begin
        delay_next = delay_cur;
`ifdef ECHO_DELAY_RAMP_EN
        if (delay_target > delay_cur) begin
            delay_next = delay_cur + ADDR_ONE;
        end else if (delay_target < delay_cur) begin
            delay_next = delay_cur - ADDR_ONE;
        end
`else
        delay_next = delay_target;
`endif
    end

    // Echo source: bypass at zero delay, silence for slots not yet written since reset
    always_comb begin
        echo_sel = rd_r;
        if (delay_cur == '0) begin
            echo_sel = sample_r;
        end else if (fill < delay_cur) begin
            echo_sel = '0;
        end
    end

    // Transaction sequencer: read old slot, write new sample, present echo
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            sample_r   <= '0;
            rd_r       <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            echo_data  <= '0;
            echo_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            delay_cur  <= '0;
        end else begin
            echo_valid <= 1'b0;
            if (data_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        sample_r  <= data_in;
                        delay_cur <= delay_next;
                        busy      <= 1'b1;
                        ram_addr  <= wr_ptr - delay_next;
                        ram_we    <= 1'b0;
                        state     <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    lat_cnt <= 3'd1;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        rd_r      <= ram_rdata;
                        ram_addr  <= wr_ptr;
                        ram_we    <= 1'b1;
                        ram_wdata <= sample_r;
                        state     <= WRITE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                WRITE: begin
                    ram_we <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    echo_valid <= 1'b1;
                    echo_data  <= echo_sel;
                    wr_ptr     <= wr_ptr + ADDR_ONE;
                    fill       <= (fill == FILL_MAX) ? fill : fill + ADDR_ONE;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - scoreboard bench for echo_delay_ctrl (default and ADDR_W=4 instances)
module tb_echo_delay_ctrl;

    logic        sysclk = 1'b0;
    logic        rst    = 1'b1;
    int          cyc    = 0;
    int          n_pass = 0;
    int          n_total = 0;

    // instance A: default parameters
    logic        a_dv = 1'b0;
    logic [9:0]  a_din = '0;
    logic [12:0] a_tgt = '0;
    logic [12:0] a_addr;
    logic        a_we;
    logic [9:0]  a_wdata;
    logic [9:0]  a_rdata = '0;
    logic [9:0]  a_r1 = '0;
    logic [9:0]  a_echo;
    logic        a_ev;
    logic        a_busy;
    logic        a_ovr;
    logic [12:0] a_dcur;
    logic [9:0]  mem_a [0:8191];

    // instance B: 16-entry delay line for wrap coverage
    logic        b_dv = 1'b0;
    logic [9:0]  b_din = '0;
    logic [3:0]  b_tgt = 4'd3;
    logic [3:0]  b_addr;
    logic        b_we;
    logic [9:0]  b_wdata;
    logic [9:0]  b_rdata = '0;
    logic [9:0]  b_r1 = '0;
    logic [9:0]  b_echo;
    logic        b_ev;
    logic        b_busy;
    logic        b_ovr;
    logic [3:0]  b_dcur;
    logic [9:0]  mem_b [0:15];

    int          we_cnt = 0;
    logic [9:0]  qa_data [$];
    int          qa_cyc [$];
    logic [9:0]  qb_data [$];

    // bench model of instance A
    logic [9:0]  hist [0:8191];
    int          m_wp = 0;
    int          m_fill = 0;
    int          m_dcur = 0;

    echo_delay_ctrl u_a (
        .sysclk(sysclk), .rst(rst), .data_valid(a_dv), .data_in(a_din),
        .delay_target(a_tgt), .ram_addr(a_addr), .ram_we(a_we), .ram_wdata(a_wdata),
        .ram_rdata(a_rdata), .echo_data(a_echo), .echo_valid(a_ev), .busy(a_busy),
        .overrun(a_ovr), .delay_cur(a_dcur)
    );

    echo_delay_ctrl #(.ADDR_W(4), .DATA_W(10), .RD_LAT(2)) u_b (
        .sysclk(sysclk), .rst(rst), .data_valid(b_dv), .data_in(b_din),
        .delay_target(b_tgt), .ram_addr(b_addr), .ram_we(b_we), .ram_wdata(b_wdata),
        .ram_rdata(b_rdata), .echo_data(b_echo), .echo_valid(b_ev), .busy(b_busy),
        .overrun(b_ovr), .delay_cur(b_dcur)
    );

    always #10 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // two-cycle read latency RAM models
    always @(posedge sysclk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        a_r1    <= mem_a[a_addr];
        a_rdata <= a_r1;
        if (b_we) mem_b[b_addr] <= b_wdata;
        b_r1    <= mem_b[b_addr];
        b_rdata <= b_r1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // echo monitors pop the scoreboards
    always @(negedge sysclk) begin
        if (a_we) we_cnt++;
        if (a_ev) begin
            if (qa_data.size() == 0) begin
                check("a_spurious_echo", 1, 0);
            end else begin
                check("a_echo_data", a_echo, qa_data.pop_front());
                check("a_echo_latency", cyc, qa_cyc.pop_front());
            end
        end
        if (b_ev) begin
            if (qb_data.size() == 0) begin
                check("b_spurious_echo", 1, 0);
            end else begin
                check("b_echo_data", b_echo, qb_data.pop_front());
            end
        end
    end

    task automatic model_accept(input logic [9:0] v, input int at_cyc, output int rd_addr);
        logic [9:0] e;
`ifdef ECHO_DELAY_RAMP_EN
        if (int'(a_tgt) > m_dcur) m_dcur++;
        else if (int'(a_tgt) < m_dcur) m_dcur--;
`else
        m_dcur = int'(a_tgt);
`endif
        rd_addr = (m_wp - m_dcur) & 8191;
        if (m_dcur == 0) e = v;
        else if (m_fill < m_dcur) e = '0;
        else e = hist[rd_addr];
        qa_data.push_back(e);
        qa_cyc.push_back(at_cyc + 6);
        hist[m_wp] = v;
        m_wp = (m_wp + 1) & 8191;
        if (m_fill < 8191) m_fill++;
    endtask

    task automatic send_a(input logic [9:0] v);
        int ra;
        we_cnt = 0;
        @(posedge sysclk); #1;
        a_din = v;
        a_dv  = 1'b1;
        model_accept(v, cyc, ra);
        @(posedge sysclk); #1;
        a_dv = 1'b0;
        check("a_rd_addr", a_addr, ra);
        check("a_rd_we_low", a_we, 0);
        repeat (8) @(posedge sysclk);
        #1;
        check("a_we_once", we_cnt, 1);
        check("a_delay_cur", a_dcur, m_dcur);
        check("a_idle", a_busy, 0);
    endtask

    initial begin
        int ra;
        int ramp_exp [4];
        repeat (3) @(posedge sysclk);
        #1 rst = 1'b0;
        @(negedge sysclk);
        check("rst_echo_valid", a_ev, 0);
        check("rst_busy", a_busy, 0);
        check("rst_overrun", a_ovr, 0);
        check("rst_delay_cur", a_dcur, 0);
        check("rst_ram_we", a_we, 0);
        check("rst_ram_addr", a_addr, 0);
        check("rst_echo_data", a_echo, 0);

        // wrap on the 16-deep instance, delay 3
        for (int n = 0; n < 40; n++) begin
            qb_data.push_back(n < 3 ? 10'd0 : 10'(n - 3));
            @(posedge sysclk); #1;
            b_din = 10'(n);
            b_dv  = 1'b1;
            @(posedge sysclk); #1;
            b_dv = 1'b0;
            check("b_rd_addr", b_addr, (n - 3) & 15);
            if ((n & 15) == 1) check("b_rd_addr_wp1", b_addr, 14);
            repeat (8) @(posedge sysclk);
        end
        check("b_overrun", b_ovr, 0);

        // delay 4, samples 1..10
        a_tgt = 13'd4;
        for (int i = 1; i <= 10; i++) send_a(10'(i));

        // zero delay bypass
        a_tgt = 13'd0;
        send_a(10'h155);

        // second pulse while busy is dropped
        a_tgt = 13'd4;
        @(posedge sysclk); #1;
        a_din = 10'h2AA;
        a_dv  = 1'b1;
        model_accept(10'h2AA, cyc, ra);
        @(posedge sysclk); #1;
        a_dv = 1'b0;
        @(posedge sysclk); #1;
        a_din = 10'h3FF;
        a_dv  = 1'b1;
        @(posedge sysclk); #1;
        a_dv = 1'b0;
        check("overrun_set", a_ovr, 1);
        repeat (8) @(posedge sysclk);
        send_a(10'h011);
        check("overrun_sticky", a_ovr, 1);

        // reset during RD_WAIT aborts the transaction
        we_cnt = 0;
        @(posedge sysclk); #1;
        a_din = 10'h0AB;
        a_dv  = 1'b1;
        @(posedge sysclk); #1;
        a_dv = 1'b0;
        @(posedge sysclk); #1;
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        check("abort_busy", a_busy, 0);
        check("abort_overrun", a_ovr, 0);
        m_wp = 0;
        m_fill = 0;
        m_dcur = 0;
        repeat (10) @(posedge sysclk);
        #1;
        check("abort_no_write", we_cnt, 0);
        a_tgt = 13'd2;
        send_a(10'h077);

        // delay step from 2 to 6
        send_a(10'h101);
        check("ramp_start", a_dcur, 2);
`ifdef ECHO_DELAY_RAMP_EN
        ramp_exp = '{3, 4, 5, 6};
`else
        ramp_exp = '{6, 6, 6, 6};
`endif
        a_tgt = 13'd6;
        for (int i = 0; i < 4; i++) begin
            send_a(10'(i + 200));
            check("ramp_step", a_dcur, ramp_exp[i]);
        end

        repeat (10) @(posedge sysclk);
        check("a_queue_drained", qa_data.size(), 0);
        check("b_queue_drained", qb_data.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/echo_delay_ctrl.md
Name: echo_delay_ctrl

Overview:
- Sequences one shared single-port sample RAM that acts as the echo delay line.
- Per ADC sample (data_valid pulse, 10 kHz):
  - reads the sample written `delay` samples earlier;
  - then writes the new sample;
  - then presents the delayed sample to the echo mixer.
- Sits between the ADC interface output and the processor's mix/scale stage. Delay comes from switch-derived configuration.

Parameters:
- ADDR_W, 13, RAM address width; depth 2^ADDR_W samples (8192 = 819.2 ms at 10 kHz).
- DATA_W, 10, sample width (matches ADC/DAC 10-bit path).
- RD_LAT, 2, RAM read latency in cycles (address registered to rdata valid); legal 1..4.

Ports:
- sysclk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- data_valid  in  1  one-cycle pulse: new sample on data_in.
- data_in  in  DATA_W  ADC sample.
- delay_target  in  ADDR_W  requested delay in samples.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after address.
- echo_data  out  DATA_W  delayed sample.
- echo_valid  out  1  one-cycle pulse: echo_data updated.
- busy  out  1  high while a sample transaction is in progress.
- overrun  out  1  sticky; set when data_valid arrives while busy.
- delay_cur  out  ADDR_W  delay actually applied to the last transaction.

Behaviour:
- Reset values:
  - ram_addr, ram_we, ram_wdata, echo_data, echo_valid, busy, overrun all 0.
  - delay_cur 0.
  - Internal registers: wr_ptr 0, fill 0, state IDLE.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE.
- IDLE, with data_valid=1:
  - latch data_in into sample_r;
  - update delay_cur (see Optional Feature);
  - busy←1;
  - go to RD_ISSUE.
- RD_ISSUE (1 cycle):
  - ram_addr = (wr_ptr − delay_cur) mod 2^ADDR_W, ram_we=0;
  - go to RD_WAIT.
- RD_WAIT (RD_LAT cycles, counted):
  - on the last cycle, capture ram_rdata into rd_r;
  - go to WRITE.
- WRITE (1 cycle):
  - ram_addr=wr_ptr, ram_we=1, ram_wdata=sample_r;
  - go to DONE.
- DONE (1 cycle):
  - echo_valid=1; echo_data = selected value (below);
  - wr_ptr←wr_ptr+1, wrapping 2^ADDR_W−1→0;
  - fill←min(fill+1, 2^ADDR_W−1);
  - busy←0;
  - go to IDLE.
- Echo value selection, priority order:
  1. delay_cur=0 → echo_data=sample_r (bypass; the read result is discarded).
  2. fill < delay_cur → echo_data=0 (slot never written since reset).
  3. otherwise echo_data=rd_r.
- Latency:
  - echo_valid asserts exactly RD_LAT+4 cycles after the data_valid cycle (6 at default).
  - The full transaction occupies the RAM for RD_LAT+3 cycles; the 5000-cycle sample period leaves ample margin.
- ram_we is high only in WRITE. ram_addr holds its last value in IDLE.
- data_valid while busy:
  - sample dropped; overrun←1, which stays set until rst;
  - in-flight transaction is unaffected.
- data_valid on the same cycle as DONE is dropped and sets overrun. A new transaction starts only from IDLE.
- delay_target changing mid-transaction has no effect until the next IDLE acceptance.
- Pointer wrap: the subtraction is modulo 2^ADDR_W. Maximum delay is 2^ADDR_W−1.
- rst asserted in any state:
  - returns to IDLE next cycle;
  - ram_we deasserts that cycle; no partial write completes after it;
  - fill is cleared, so stale RAM contents are masked to 0.

Optional Feature:
- Macro: ECHO_DELAY_RAMP_EN.
- Defined: delay_cur slews toward delay_target by at most 1 per accepted sample (±1, or hold when equal). This gives click-free delay changes.
- Undefined: delay_cur←delay_target directly at each acceptance.
- Reset value is 0 in both cases.

Test Plan:
- Reset, then delay_target=4; feed samples 1,2,3,…,10 at 10 kHz → echo_data 0,0,0,0,1,2,3,4,5,6; each echo_valid arrives 6 cycles after its data_valid; ram_we exactly one cycle per sample.
- delay_target=0; feed 0x155 → echo_data=0x155; one read and one write still issued.
- ADDR_W=4 build, delay=3; feed 40 samples (value=index) → wr_ptr wraps 15→0; after wrap, sample n echoes n−3; read address at wr_ptr=1 is 14.
- Pulse data_valid 2 cycles after an accepted pulse → second sample ignored, overrun=1 and sticky; the first echo completes normally.
- Assert rst during RD_WAIT → next cycle busy=0, ram_we never asserts, fill=0; a subsequent sample with delay=2 echoes 0.
- ECHO_DELAY_RAMP_EN defined, delay_cur=2, step target to 6 → delay_cur goes 3,4,5,6 over the next 4 samples. Without the macro → 6 immediately.
